// File: rtl/rv_lsu_bridge.sv
// ============================================================================
// Module   : rv_lsu_bridge
// Purpose  : Load/store bridge between the core's data-memory strobes and a
//            valid/ready data bus with wait states. Stalls the core while a
//            transfer is in flight, builds byte enables and lane-replicated
//            store data, and sign/zero-extends load data. Misaligned, illegal
//            and timed-out accesses raise a one-cycle error pulse.
// Ports    : clk, reset_n (sync, active low)
//            core side : data_mem_read, data_mem_write, data_mem_addr,
//                        write_data, store_type, load_type -> stall, read_data
//            errors    : err_valid (pulse), err_code (01 mis, 10 tmo, 11 ill)
//            bus side  : bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
//                        bus_ready, bus_rdata
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_lsu_bridge #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                data_mem_read,
    input  logic                data_mem_write,
    input  logic [ADDR_W-1:0]   data_mem_addr,
    input  logic [XLEN-1:0]     write_data,
    input  logic [1:0]          store_type,
    input  logic [2:0]          load_type,
    output logic                stall,
    output logic [XLEN-1:0]     read_data,
    output logic                err_valid,
    output logic [1:0]          err_code,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic [XLEN-1:0]     bus_rdata
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [1:0] C_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] C_ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] C_ERR_ILLEGAL  = 2'b11;

    localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_wait;
    logic              r_bus_valid;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [BE_W-1:0]   r_bus_be;
    logic [XLEN-1:0]   r_bus_wdata;
    logic [XLEN-1:0]   r_read_data;
    logic              r_err_valid;
    logic [1:0]        r_err_code;
    logic [2:0]        r_load_type;
    logic [OFF_W-1:0]  r_off;

    // ------------------------------------------------------------------------
    // Request classification (evaluated in IDLE)
    // ------------------------------------------------------------------------
    logic              w_req;
    logic              w_xlen32;
    logic [1:0]        w_size_log2;
    logic              w_illegal;
    logic              w_misaligned;
    logic [OFF_W-1:0]  w_off;
    logic [BE_W-1:0]   w_mask;
    logic [BE_W-1:0]   w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [ADDR_W-1:0] w_bus_addr;

    assign w_req    = data_mem_read | data_mem_write;
    assign w_xlen32 = (XLEN == 32);

    // load_type[1:0] already encodes log2(size) for both the signed and the
    // unsigned variants (LBU=100 -> byte, LHU=101 -> half, LWU=110 -> word).
    assign w_size_log2 = (data_mem_write && !data_mem_read) ? store_type
                                                            : load_type[1:0];

    assign w_illegal = (data_mem_read && data_mem_write)
                     || (data_mem_read && (load_type == 3'b111))
                     || (w_xlen32 && data_mem_write && (store_type == 2'b11))
                     || (w_xlen32 && data_mem_read
                         && ((load_type == 3'b011) || (load_type == 3'b110)));

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size_log2)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = data_mem_addr[0];
            2'd2:    w_misaligned = |data_mem_addr[1:0];
            default: w_misaligned = |data_mem_addr[2:0];
        endcase
    end

    assign w_off      = data_mem_addr[OFF_W-1:0];
    assign w_bus_addr = data_mem_addr & ~ADDR_W'(BE_W - 1);

    always_comb begin
        w_mask  = '1;
        w_wdata = write_data;
        case (w_size_log2)
            2'd0: begin
                w_mask  = BE_W'(1);
                w_wdata = {BE_W{write_data[7:0]}};
            end
            2'd1: begin
                w_mask  = BE_W'(3);
                w_wdata = {(BE_W/2){write_data[15:0]}};
            end
            2'd2: begin
                w_mask  = BE_W'(15);
                w_wdata = {(BE_W/4){write_data[31:0]}};
            end
            default: begin
                w_mask  = '1;
                w_wdata = write_data;
            end
        endcase
    end

    assign w_be = w_mask << w_off;

    // ------------------------------------------------------------------------
    // Load data extraction: move the addressed lane to bit 0, then extend
    // ------------------------------------------------------------------------
    logic [OFF_W+2:0] w_shamt;
    logic [XLEN-1:0]  w_lane;
    logic [XLEN-1:0]  w_load_result;

    assign w_shamt = {r_off, 3'b000};
    assign w_lane  = bus_rdata >> w_shamt;

    always_comb begin
        w_load_result = w_lane;
        case (r_load_type)
            3'b000:  w_load_result = XLEN'($signed(w_lane[7:0]));
            3'b001:  w_load_result = XLEN'($signed(w_lane[15:0]));
            3'b010:  w_load_result = XLEN'($signed(w_lane[31:0]));
            3'b100:  w_load_result = XLEN'(w_lane[7:0]);
            3'b101:  w_load_result = XLEN'(w_lane[15:0]);
            3'b110:  w_load_result = XLEN'(w_lane[31:0]);
            default: w_load_result = w_lane;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_read_data <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'b00;
            r_load_type <= 3'b000;
            r_off       <= '0;
        end else begin
            // err_valid is a single-cycle pulse; only the ERR entry raises it
            r_err_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_illegal) begin
                            r_state     <= S_ERR;
                            r_err_valid <= 1'b1;
                            r_err_code  <= C_ERR_ILLEGAL;
                        end else if (w_misaligned) begin
                            r_state     <= S_ERR;
                            r_err_valid <= 1'b1;
                            r_err_code  <= C_ERR_MISALIGN;
                        end else begin
                            r_state     <= S_REQ;
                            r_wait      <= '0;
                            r_bus_valid <= 1'b1;
                            r_bus_we    <= data_mem_write;
                            r_bus_addr  <= w_bus_addr;
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                            r_load_type <= load_type;
                            r_off       <= w_off;
                        end
                    end
                end
                S_REQ: begin
                    // ready is checked first so it wins in the final wait cycle
                    if (bus_ready) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= S_DONE;
                        if (!r_bus_we) begin
                            r_read_data <= w_load_result;
                        end
                    end else if (r_wait == C_WAIT_LAST) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= S_ERR;
                        r_err_valid <= 1'b1;
                        r_err_code  <= C_ERR_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // DONE and ERR deliberately do not stall: the core retires (or traps) in
    // that cycle while the request strobes may still be visible.
    assign stall = reset_n & (((r_state == S_IDLE) & w_req) | (r_state == S_REQ));

    assign read_data = r_read_data;
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign bus_valid = r_bus_valid;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_rv_lsu_bridge.sv
// ============================================================================
// Module   : tb_rv_lsu_bridge
// Purpose  : Self-checking bench for rv_lsu_bridge. One 32-bit and one 64-bit
//            instance share clock, reset and the common request fields; each
//            access is predicted by a byte-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_lsu_bridge;

    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rd_s = '0;     // index 0: 32-bit DUT, index 1: 64-bit DUT
    logic [1:0]  wr_s = '0;
    logic [1:0]  rdy_s = '0;
    logic [2:0]  load_type = '0;
    logic [1:0]  store_type = '0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata = '0;
    logic        sel = 1'b0;

    logic        stall32, ev32, bv32, bwe32;
    logic [1:0]  ec32;
    logic [31:0] rd32, ba32, bwd32;
    logic [3:0]  bbe32;
    logic        stall64, ev64, bv64, bwe64;
    logic [1:0]  ec64;
    logic [63:0] rd64, bwd64;
    logic [31:0] ba64;
    logic [7:0]  bbe64;

    always #5 clk = ~clk;

    rv_lsu_bridge #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut32 (
        .clk(clk), .reset_n(reset_n),
        .data_mem_read(rd_s[0]), .data_mem_write(wr_s[0]),
        .data_mem_addr(addr), .write_data(wdata[31:0]),
        .store_type(store_type), .load_type(load_type),
        .stall(stall32), .read_data(rd32),
        .err_valid(ev32), .err_code(ec32),
        .bus_valid(bv32), .bus_ready(rdy_s[0]), .bus_we(bwe32),
        .bus_addr(ba32), .bus_be(bbe32), .bus_wdata(bwd32),
        .bus_rdata(rdata[31:0])
    );

    rv_lsu_bridge #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .data_mem_read(rd_s[1]), .data_mem_write(wr_s[1]),
        .data_mem_addr(addr), .write_data(wdata),
        .store_type(store_type), .load_type(load_type),
        .stall(stall64), .read_data(rd64),
        .err_valid(ev64), .err_code(ec64),
        .bus_valid(bv64), .bus_ready(rdy_s[1]), .bus_we(bwe64),
        .bus_addr(ba64), .bus_be(bbe64), .bus_wdata(bwd64),
        .bus_rdata(rdata)
    );

    // Outputs of the currently selected instance, zero-extended to 64 bits
    logic        o_stall, o_ev, o_bv, o_bwe;
    logic [1:0]  o_ec;
    logic [63:0] o_rd, o_ba, o_be, o_bwd;

    always_comb begin
        o_stall = sel ? stall64 : stall32;
        o_ev    = sel ? ev64    : ev32;
        o_ec    = sel ? ec64    : ec32;
        o_bv    = sel ? bv64    : bv32;
        o_bwe   = sel ? bwe64   : bwe32;
        o_rd    = sel ? rd64    : {32'b0, rd32};
        o_ba    = sel ? {32'b0, ba64}  : {32'b0, ba32};
        o_be    = sel ? {56'b0, bbe64} : {60'b0, bbe32};
        o_bwd   = sel ? bwd64   : {32'b0, bwd32};
    end

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_rd [2];
    logic [1:0]  last_err [2];
    logic [63:0] obs_baddr, obs_be, obs_wdata;
    int          obs_stall_cnt, obs_vcnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------------
    function automatic int size_of(input bit rd, input logic [2:0] lt, input logic [1:0] st);
        if (!rd) return 1 << st;
        case (lt)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    function automatic logic [1:0] model_err(input bit x64, input bit rd, input bit wr,
                                             input logic [2:0] lt, input logic [1:0] st,
                                             input logic [31:0] a);
        if (rd && wr) return 2'b11;
        if (rd && lt == 3'd7) return 2'b11;
        if (!x64 && ((wr && st == 2'd3) || (rd && (lt == 3'd3 || lt == 3'd6)))) return 2'b11;
        if ((a % size_of(rd, lt, st)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [63:0] model_load(input bit x64, input logic [2:0] lt,
                                               input logic [31:0] a, input logic [63:0] rdat);
        int nb, off, sz;
        logic [63:0] v, mask;
        nb = x64 ? 8 : 4;
        off = int'(a % nb);
        sz = size_of(1'b1, lt, 2'd0);
        v = rdat >> (8 * off);
        if (sz < 8) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            v = v & mask;
            if (lt < 3'd4 && ((v >> (8 * sz - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        end
        if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] model_wdata(input bit x64, input int sz, input logic [63:0] wd);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < (x64 ? 8 : 4); i++)
            v = v | (((wd >> (8 * (i % sz))) & 64'hFF) << (8 * i));
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // One complete memory instruction; waitc = bus wait cycles before ready
    // (waitc >= TB_TIMEOUT means ready never arrives).
    // ------------------------------------------------------------------------
    task automatic access(input bit x64, input bit rd, input bit wr,
                          input logic [2:0] lt, input logic [1:0] st,
                          input logic [31:0] a, input logic [63:0] wd,
                          input logic [63:0] rdat, input int waitc);
        logic [1:0] e, code;
        int sz, nb, off, exp_v, stall_cnt, vcnt;
        bit done, to;
        e   = model_err(x64, rd, wr, lt, st, a);
        sz  = size_of(rd, lt, st);
        nb  = x64 ? 8 : 4;
        off = int'(a % nb);
        to  = (e == 2'b00) && (waitc >= TB_TIMEOUT);
        exp_v = (e != 2'b00) ? 0 : (to ? TB_TIMEOUT : waitc + 1);

        @(negedge clk);
        sel = x64;
        rd_s = '0; wr_s = '0; rdy_s = '0;
        rd_s[x64] = rd; wr_s[x64] = wr;
        load_type = lt; store_type = st; addr = a; wdata = wd; rdata = rdat;
        #1;
        check("idle_stall", {63'b0, o_stall}, 64'd1);
        stall_cnt = o_stall ? 1 : 0;
        vcnt = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            #1;
            if (o_stall) stall_cnt++;
            if (o_bv) begin
                if (vcnt == 0) begin
                    obs_baddr = o_ba; obs_be = o_be; obs_wdata = o_bwd;
                    check("bus_addr", o_ba, 64'(a - 32'(off)));
                    check("bus_be", o_be, ((64'd1 << sz) - 64'd1) << off);
                    check("bus_we", {63'b0, o_bwe}, {63'b0, wr});
                    if (wr) check("bus_wdata", o_bwd, model_wdata(x64, sz, wd));
                end
                rdy_s[x64] = (vcnt == waitc);
                vcnt++;
            end else begin
                done = 1'b1;
                rdy_s = '0;
                if (e != 2'b00 || to) begin
                    code = (e != 2'b00) ? e : 2'b10;
                    check("err_valid", {63'b0, o_ev}, 64'd1);
                    check("err_code", {62'b0, o_ec}, {62'b0, code});
                    last_err[x64] = code;
                end else begin
                    check("no_err", {63'b0, o_ev}, 64'd0);
                    check("err_code_hold", {62'b0, o_ec}, {62'b0, last_err[x64]});
                    if (rd) exp_rd[x64] = model_load(x64, lt, a, rdat);
                end
                check("read_data", o_rd, exp_rd[x64]);
                rd_s = '0; wr_s = '0;
            end
        end
        check("cycle_bound", {63'b0, done}, 64'd1);
        check("valid_cycles", 64'(vcnt), 64'(exp_v));
        check("stall_cycles", 64'(stall_cnt), 64'(exp_v + 1));
        obs_stall_cnt = stall_cnt;
        obs_vcnt = vcnt;
        rd_s = '0; wr_s = '0; rdy_s = '0;
        @(negedge clk);
        #1;
        check("gap_stall", {63'b0, o_stall}, 64'd0);
        check("gap_valid", {63'b0, o_bv}, 64'd0);
        check("gap_err", {63'b0, o_ev}, 64'd0);
    endtask

    initial begin
        int kind, wsel;
        bit x64, rd, wr;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_err[0] = 2'b00; last_err[1] = 2'b00;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall32", {63'b0, stall32}, 64'd0);
        check("rst_stall64", {63'b0, stall64}, 64'd0);
        check("rst_valid", {62'b0, bv64, bv32}, 64'd0);
        check("rst_rd32", {32'b0, rd32}, 64'd0);
        check("rst_rd64", rd64, 64'd0);
        check("rst_err", {58'b0, ev32, ev64, ec32, ec64}, 64'd0);
        reset_n = 1'b1;

        // Byte store with immediate ready
        access(0, 0, 1, 3'd0, 2'd0, 32'h103, 64'hAB, 64'h0, 0);
        check("sb_addr", obs_baddr, 64'h100);
        check("sb_be", obs_be, 64'b1000);
        check("sb_wdata", obs_wdata, 64'hABAB_ABAB);
        check("sb_stall", 64'(obs_stall_cnt), 64'd2);

        // LB / LBU with three wait cycles
        access(0, 1, 0, 3'd0, 2'd0, 32'h102, 64'h0, 64'h0080_0000, 3);
        check("lb_data", o_rd, 64'hFFFF_FF80);
        check("lb_stall", 64'(obs_stall_cnt), 64'd5);
        access(0, 1, 0, 3'd4, 2'd0, 32'h102, 64'h0, 64'h0080_0000, 3);
        check("lbu_data", o_rd, 64'h0000_0080);

        // Misaligned and illegal
        access(0, 1, 0, 3'd1, 2'd0, 32'h101, 64'h0, 64'h0, 0);
        check("mis_code", {62'b0, o_ec}, 64'd1);
        check("mis_stall", 64'(obs_stall_cnt), 64'd1);
        access(0, 1, 1, 3'd2, 2'd2, 32'h104, 64'h0, 64'h0, 0);
        check("ill_code", {62'b0, o_ec}, 64'd3);

        // Timeout, then ready in the final wait cycle
        access(0, 1, 0, 3'd2, 2'd0, 32'h200, 64'h0, 64'h1234_5678, 1000);
        check("tmo_valid", 64'(obs_vcnt), 64'd16);
        access(0, 1, 0, 3'd2, 2'd0, 32'h200, 64'h0, 64'h1234_5678, 15);
        check("tmo_edge_data", o_rd, 64'h1234_5678);

        // 64-bit word loads from the upper lane
        access(1, 1, 0, 3'd6, 2'd0, 32'h1004, 64'h0, 64'h89AB_CDEF_0000_0000, 0);
        check("lwu64", o_rd, 64'h0000_0000_89AB_CDEF);
        access(1, 1, 0, 3'd2, 2'd0, 32'h1004, 64'h0, 64'h89AB_CDEF_0000_0000, 1);
        check("lw64", o_rd, 64'hFFFF_FFFF_89AB_CDEF);

        // Reset asserted in the second REQ cycle
        @(negedge clk);
        sel = 1'b0; rd_s = 2'b01; wr_s = '0; rdy_s = '0;
        load_type = 3'd0; addr = 32'h102;
        @(negedge clk);
        #1;
        check("mid_req_valid", {63'b0, o_bv}, 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_stall", {63'b0, o_stall}, 64'd0);
        @(negedge clk);
        #1;
        check("post_rst_valid", {63'b0, o_bv}, 64'd0);
        check("post_rst_rd", o_rd, 64'd0);
        reset_n = 1'b1;
        rd_s = '0;
        #1;
        check("post_rst_stall", {63'b0, o_stall}, 64'd0);
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_err[0] = 2'b00; last_err[1] = 2'b00;
        access(0, 1, 0, 3'd1, 2'd0, 32'h206, 64'h0, 64'h8001_0000, 1);

        // Randomised accesses against the model
        for (int n = 0; n < 40; n++) begin
            x64  = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 7));
            rd   = (kind <= 3) || (kind == 7);
            wr   = (kind >= 4);
            wsel = int'($urandom_range(0, 7));
            access(x64, rd, wr, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   $urandom, {$urandom, $urandom}, {$urandom, $urandom},
                   (wsel == 6) ? 15 : ((wsel == 7) ? 40 : wsel));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_lsu_bridge.md
Name: rv_lsu_bridge

Overview:
- Parametrised load/store bridge between the core's data-memory strobes and a valid/ready data bus with wait states.
- Holds the core with a stall while a transfer is in flight, and generates byte enables and lane-replicated write data.
- Extracts and sign- or zero-extends load data.
- Detects misaligned, illegal and timed-out accesses.
- Successor to the fixed zero-wait, 32-bit-only core memory path; supports XLEN 32/64 and bounded bus latency.

Parameters:
XLEN, 32, data width, 32 or 64; bus byte-enable width BE_W = XLEN/8, OFF_W = log2(BE_W).
ADDR_W, 32, address width.
TIMEOUT, 16, maximum cycles waiting for bus_ready (>=2).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  synchronous active-low reset.
data_mem_read  in  1  core load request.
data_mem_write  in  1  core store request.
data_mem_addr  in  ADDR_W  byte address.
write_data  in  XLEN  store data, right-aligned.
store_type  in  2  00 byte, 01 half, 10 word, 11 double.
load_type  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
stall  out  1  freeze PC and register writeback.
read_data  out  XLEN  extended load result, registered.
err_valid  out  1  one-cycle error pulse.
err_code  out  2  01 misaligned, 10 timeout, 11 illegal.
bus_valid  out  1  request valid.
bus_ready  in  1  slave accept; bus_rdata valid in the same cycle.
bus_we  out  1  write.
bus_addr  out  ADDR_W  address with low OFF_W bits cleared.
bus_be  out  BE_W  byte enables.
bus_wdata  out  XLEN  lane-replicated store data.
bus_rdata  in  XLEN  read data.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state goes to IDLE.
  - All registered outputs (bus_*, read_data, err_valid, err_code) go to 0.
  - stall is 0 while reset_n is low.
  - Reset mid-transfer abandons the transfer; bus_valid is low the next cycle.
- States: IDLE, REQ, DONE, ERR.
- stall = reset_n & ((IDLE & (data_mem_read | data_mem_write)) | REQ). stall is combinational and low in DONE and ERR.
- IDLE with a request: the access is classified in this cycle.
  - Illegal (code 11) when:
    - read and write are both high;
    - load_type is 111;
    - XLEN=32 and the access is store_type 11 or load_type 011/110.
  - Misaligned (code 01): address not a multiple of the access size.
    - Illegal takes priority over misaligned.
  - On error: go to ERR, no bus access.
  - Otherwise: go to REQ with registered bus outputs:
    - bus_valid = 1.
    - bus_we = write.
    - bus_addr = addr & ~(BE_W-1).
    - bus_be = size mask shifted left by offset (addr[OFF_W-1:0]).
    - bus_wdata = write_data low bytes replicated across all lanes.
- REQ:
  - Hold bus_valid, bus_we, bus_addr, bus_be and bus_wdata stable until bus_ready.
  - A wait counter starts at 0 on REQ entry.
  - bus_ready=1: drop bus_valid and go to DONE.
    - For loads, in the same cycle: read_data <= extend(bus_rdata >> (offset*8)).
    - Extension: sign for LB/LH/LW; zero for LBU/LHU/LWU; none for LD.
  - bus_ready=0 with counter == TIMEOUT-1: drop bus_valid and go to ERR with code 10.
  - Otherwise the counter increments.
  - bus_ready arriving in the timeout cycle counts as success; ready wins.
- DONE: one cycle with stall=0, so the core retires with read_data valid; then go to IDLE.
  - The request that is still visible in DONE is not re-issued.
  - Stores leave read_data unchanged.
- ERR: one cycle with err_valid=1, err_code set, stall=0; then go to IDLE.
  - err_code holds until the next error.
  - err_valid is low in all other states.
- Latency: minimum 3 cycles per memory instruction (IDLE, REQ with immediate ready, DONE). Each bus wait cycle adds 1.
- Non-memory instructions (both strobes low) never stall.

Test Plan:
- XLEN=32, store_type 00, addr 0x103, write_data 0xAB, bus_ready at first REQ cycle -> bus_addr 0x100, bus_be 1000, bus_wdata 0xABABABAB, bus_we 1, stall high for exactly 2 cycles.
- XLEN=32, LB at 0x102, bus_rdata 0x00800000, ready after 3 wait cycles -> read_data 0xFFFFFF80 in DONE, stall high 5 cycles. Repeat as LBU -> 0x00000080.
- XLEN=32, LH at 0x101 -> no bus_valid, err_valid pulse with err_code 01, stall high 1 cycle only. LW at 0x104 with read and write both high -> err_code 11.
- TIMEOUT=16, bus_ready held 0 -> bus_valid high exactly 16 cycles, then err_code 10. Repeat with ready in the 16th cycle -> DONE, no error.
- XLEN=64, LWU at 0x...04, bus_rdata 0x89ABCDEF_00000000 -> read_data 0x00000000_89ABCDEF. LW at the same address -> 0xFFFFFFFF_89ABCDEF.
- reset_n low for 1 cycle in the 2nd REQ cycle -> next cycle bus_valid 0, stall 0, state IDLE. A fresh request afterwards completes normally.
